mpr121_scanner: RTL

//  Parametrised MPR121 capacitive-touch controller driving i2c_master's AXI-stream cmd/data ports.

---
 rtl/mpr121_scanner.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/mpr121_scanner.sv
// MPR121 touch scanner: drives i2c_master cmd/data streams through the init table, then polls and debounces.
// Latency: touch/touch_valid update one cycle after the second status byte is accepted; polls every POLL_CYCLES.
// Backpressure: valids held with stable payload until ready; each handshake wait is bounded by TIMEOUT_CYCLES.
module mpr121_scanner #(
    parameter logic [6:0] DEV_ADDR       = 7'h5A,
    parameter int         NUM_ELECTRODES = 12,
    parameter logic [7:0] TOUCH_THRESH   = 8'h0F,
    parameter logic [7:0] RELEASE_THRESH = 8'h0A,
    parameter int         POLL_CYCLES    = 4095,
    parameter int         DEBOUNCE       = 2,
    parameter int         TIMEOUT_CYCLES = 1000000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    output logic [6:0]                cmd_address,
    output logic                      cmd_start,
    output logic                      cmd_read,
    output logic                      cmd_write,
    output logic                      cmd_write_multiple,
    output logic                      cmd_stop,
    output logic                      cmd_valid,
    input  logic                      cmd_ready,
    output logic [7:0]                tx_tdata,
    output logic                      tx_tvalid,
    output logic                      tx_tlast,
    input  logic                      tx_tready,
    input  logic [7:0]                rx_tdata,
    input  logic                      rx_tvalid,
    output logic                      rx_tready,
    input  logic                      missed_ack,
    output logic [NUM_ELECTRODES-1:0] touch,
    output logic                      touch_valid,
    output logic                      init_done,
    output logic                      error,
    output logic [7:0]                error_count
);

    localparam int          N          = NUM_ELECTRODES;
    localparam logic [4:0]  LAST_IDX   = 5'(2 * N + 1);
    localparam logic [3:0]  DEB_L      = 4'(DEBOUNCE);
    localparam logic [31:0] POLL_LAST  = 32'(POLL_CYCLES - 1);
    localparam logic [31:0] TO_LAST    = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]  ECR_VAL    = {4'h0, 4'(N)};

    typedef enum logic [3:0] {
        S_IDLE,
        S_CFG_CMD,
        S_CFG_REG,
        S_CFG_VAL,
        S_POLL_WAIT,
        S_PTR_CMD,
        S_PTR_DATA,
        S_RD0_CMD,
        S_RD0,
        S_RD1_CMD,
        S_RD1,
        S_BACKOFF
    } state_t;

    state_t              state_q, state_d;
    logic [4:0]          idx_q, idx_d;
    logic [31:0]         timer_q, timer_d;
    logic [7:0]          rx0_q, rx0_d;
    logic [N-1:0]        touch_q, touch_d;
    logic [N-1:0][3:0]   deb_q, deb_d;
    logic                touch_valid_q, touch_valid_d;
    logic                init_done_q, init_done_d;
    logic                error_q, error_d;
    logic [7:0]          error_count_q, error_count_d;

    logic [7:0]          entry_reg, entry_val;
    logic                cmd_xfer, tx_xfer, rx_xfer, any_xfer, waiting;
    logic                timeout_hit, ovcf, fault, sample_xfer;
    logic [11:0]         raw;
    logic                unused_bits;

    // Init table: entry 0 is soft reset, 1..2N are interleaved touch/release
    // thresholds (register 0x41+k for k = idx-1), the last entry enables electrodes.
    always_comb begin
        entry_reg = 8'h40 + {3'b000, idx_q};
        entry_val = idx_q[0] ? TOUCH_THRESH : RELEASE_THRESH;
        if (idx_q == 5'd0) begin
            entry_reg = 8'h80;
            entry_val = 8'h63;
        end else if (idx_q == LAST_IDX) begin
            entry_reg = 8'h5E;
            entry_val = ECR_VAL;
        end
    end

    // Stream outputs are pure decodes of the registered state, so payload is stable while stalled.
    always_comb begin
        cmd_valid          = (state_q == S_CFG_CMD) || (state_q == S_PTR_CMD) ||
                             (state_q == S_RD0_CMD) || (state_q == S_RD1_CMD);
        cmd_address        = cmd_valid ? DEV_ADDR : 7'd0;
        cmd_start          = (state_q == S_CFG_CMD) || (state_q == S_PTR_CMD) || (state_q == S_RD0_CMD);
        cmd_read           = (state_q == S_RD0_CMD) || (state_q == S_RD1_CMD);
        cmd_write          = (state_q == S_PTR_CMD);
        cmd_write_multiple = (state_q == S_CFG_CMD);
        cmd_stop           = (state_q == S_CFG_CMD) || (state_q == S_RD1_CMD);
        tx_tvalid          = (state_q == S_CFG_REG) || (state_q == S_CFG_VAL) || (state_q == S_PTR_DATA);
        tx_tlast           = (state_q == S_CFG_VAL) || (state_q == S_PTR_DATA);
        tx_tdata           = 8'h00;
        if (state_q == S_CFG_REG) tx_tdata = entry_reg;
        if (state_q == S_CFG_VAL) tx_tdata = entry_val;
        rx_tready          = (state_q == S_RD0) || (state_q == S_RD1);
    end

    // Handshakes and fault detection; a fault overrides every other update this cycle.
    always_comb begin
        cmd_xfer    = cmd_valid && cmd_ready;
        tx_xfer     = tx_tvalid && tx_tready;
        rx_xfer     = rx_tready && rx_tvalid;
        any_xfer    = cmd_xfer || tx_xfer || rx_xfer;
        waiting     = cmd_valid || tx_tvalid || rx_tready;
        timeout_hit = waiting && !any_xfer && (timer_q >= TO_LAST);
        sample_xfer = (state_q == S_RD1) && rx_xfer;
        ovcf        = sample_xfer && rx_tdata[7];
        fault       = ((state_q != S_IDLE) && missed_ack) || ovcf || timeout_hit;
    end

    // Sequencer next state: config table, poll loop, parking and back-off.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        init_done_d = init_done_q;
        case (state_q)
            S_IDLE: begin
                idx_d = 5'd0;
                if (enable) state_d = S_CFG_CMD;
            end
            S_CFG_CMD:  if (cmd_xfer) state_d = S_CFG_REG;
            S_CFG_REG:  if (tx_xfer)  state_d = S_CFG_VAL;
            S_CFG_VAL: begin
                if (tx_xfer) begin
                    if (idx_q == LAST_IDX) begin
                        init_done_d = 1'b1;
                        state_d     = S_POLL_WAIT;
                    end else begin
                        idx_d   = idx_q + 5'd1;
                        state_d = enable ? S_CFG_CMD : S_IDLE;
                    end
                end
            end
            S_POLL_WAIT: if (timer_q >= POLL_LAST && enable) state_d = S_PTR_CMD;
            S_PTR_CMD:   if (cmd_xfer) state_d = S_PTR_DATA;
            // Parking after the pointer write leaves the read for the next poll.
            S_PTR_DATA:  if (tx_xfer)  state_d = enable ? S_RD0_CMD : S_POLL_WAIT;
            S_RD0_CMD:   if (cmd_xfer) state_d = S_RD0;
            S_RD0:       if (rx_xfer)  state_d = S_RD1_CMD;
            S_RD1_CMD:   if (cmd_xfer) state_d = S_RD1;
            S_RD1:       if (rx_xfer)  state_d = S_POLL_WAIT;
            S_BACKOFF: begin
                idx_d = 5'd0;
                if (timer_q >= POLL_LAST) state_d = enable ? S_CFG_CMD : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (fault) begin
            state_d     = S_BACKOFF;
            idx_d       = 5'd0;
            init_done_d = 1'b0;
        end
    end

    // Shared timer: restarts on every state change or fault, otherwise counts up and saturates.
    always_comb begin
        timer_d = timer_q;
        if (fault || (state_d != state_q)) timer_d = 32'd0;
        else if (timer_q != 32'hFFFF_FFFF) timer_d = timer_q + 32'd1;
    end

    // Per-electrode debounce: a disagreeing sample counts up, an agreeing one clears the count.
    always_comb begin
        touch_d       = touch_q;
        deb_d         = deb_q;
        touch_valid_d = 1'b0;
        raw           = {rx_tdata[3:0], rx0_q};
        if (fault) begin
            touch_d       = '0;
            deb_d         = '0;
            touch_valid_d = |touch_q;
        end else if (sample_xfer) begin
            for (int i = 0; i < N; i++) begin
                if (raw[i] != touch_q[i]) begin
                    if (({1'b0, deb_q[i]} + 5'd1) >= {1'b0, DEB_L}) begin
                        touch_d[i] = ~touch_q[i];
                        deb_d[i]   = 4'd0;
                    end else begin
                        deb_d[i] = deb_q[i] + 4'd1;
                    end
                end else begin
                    deb_d[i] = 4'd0;
                end
            end
            touch_valid_d = (touch_d != touch_q);
        end
    end

    // First status byte capture and fault bookkeeping.
    always_comb begin
        rx0_d         = rx0_q;
        error_d       = fault;
        error_count_d = error_count_q;
        if ((state_q == S_RD0) && rx_xfer) rx0_d = rx_tdata;
        if (fault && (error_count_q != 8'hFF)) error_count_d = error_count_q + 8'd1;
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            idx_q         <= 5'd0;
            timer_q       <= 32'd0;
            rx0_q         <= 8'd0;
            touch_q       <= '0;
            deb_q         <= '0;
            touch_valid_q <= 1'b0;
            init_done_q   <= 1'b0;
            error_q       <= 1'b0;
            error_count_q <= 8'd0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            timer_q       <= timer_d;
            rx0_q         <= rx0_d;
            touch_q       <= touch_d;
            deb_q         <= deb_d;
            touch_valid_q <= touch_valid_d;
            init_done_q   <= init_done_d;
            error_q       <= error_d;
            error_count_q <= error_count_d;
        end
    end

    assign touch       = touch_q;
    assign touch_valid = touch_valid_q;
    assign init_done   = init_done_q;
    assign error       = error_q;
    assign error_count = error_count_q;

    // Status bits 6:4 of the second byte and electrodes beyond N carry nothing we report.
    assign unused_bits = &{1'b0, rx_tdata[6:4], raw};

endmodule
